// File: rtl/seven_segment_capture_pkg.sv
// Shared constants for the seven-segment capture block: active-low segment
// patterns ({g..a}) matching the display encoder, and capture FSM state codes.
package seven_segment_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the display encoder: 7-bit active-low pattern to
// hex nibble. Unknown patterns (including blank) decode to 0 and flag illegal.
module seven_segment_pattern_decode
  import seven_segment_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of the seven-segment interface: synchronizes the scanned bus,
// captures each settled digit into a slot, and publishes a word per full frame.
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [6:0]              SEG_IN,
  input  logic [NUM_DIGITS-1:0]   DIG_SEL,
  output logic [4*NUM_DIGITS-1:0] VALUE,
  output logic                    VALUE_VALID,
  output logic [NUM_DIGITS-1:0]   DIGIT_ERR,
  output logic [1:0]              dbg_state
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  // The first cycle of a new one-hot select already counts as one stable cycle.
  localparam logic [1:0] FIRST_STATE = (SETTLE_CYCLES <= 1) ? CAPTURE : SETTLE;

  logic [6:0]              seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0]   sel_s1, sel_s2, sel_prev, cap_sel;
  logic [1:0]              state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] slot_val;
  logic [NUM_DIGITS-1:0]   slot_err, seen, cap_mask;
  logic [3:0]              dec_nibble;
  logic                    dec_illegal, sel_onehot, stable, publish;

  seven_segment_pattern_decode u_decode (
    .pattern (seg_prev),
    .nibble  (dec_nibble),
    .illegal (dec_illegal)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      seg_s1   <= SEG_BLANK;
      seg_s2   <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      sel_s1   <= '0;
      sel_s2   <= '0;
      sel_prev <= '0;
    end else begin
      seg_s1   <= SEG_IN;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= DIG_SEL;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  assign sel_onehot = $onehot(sel_s2);
  assign stable     = (sel_s2 == sel_prev) && (seg_s2 == seg_prev);
  assign publish    = &seen;
  // In CAPTURE the validated pattern/select are one cycle old (seg_prev/sel_prev).
  assign cap_mask   = (state == CAPTURE) ? sel_prev : '0;
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (sel_onehot) begin
          state_nx = FIRST_STATE;
          cnt_nx   = CW'(1);
        end
      end
      SETTLE: begin
        if (!stable) begin
          state_nx = sel_onehot ? FIRST_STATE : IDLE;
          cnt_nx   = CW'(1);
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_nx = CAPTURE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        state_nx = HOLD;
        if (sel_s2 != sel_prev) begin
          state_nx = sel_onehot ? FIRST_STATE : IDLE;
          cnt_nx   = CW'(1);
        end
      end
      default: begin
        if (sel_s2 != cap_sel) begin
          state_nx = sel_onehot ? FIRST_STATE : IDLE;
          cnt_nx   = CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      cap_sel <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == CAPTURE) cap_sel <= sel_prev;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_val    <= '0;
      slot_err    <= '0;
      seen        <= '0;
      VALUE       <= '0;
      DIGIT_ERR   <= '0;
      VALUE_VALID <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          slot_val[4*i +: 4] <= dec_nibble;
          slot_err[i]        <= dec_illegal;
        end
      end
      seen        <= (publish ? '0 : seen) | cap_mask;
      VALUE_VALID <= publish;
      if (publish) begin
        VALUE     <= slot_val;
        DIGIT_ERR <= slot_err;
      end
    end
  end

endmodule
